// File: rtl/key_ctrl_if.sv
// Key controller bus: raw key levels in, key events and user settings out.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is a level or a one-cycle pulse.
//
// Signals:
//   key_value [2:0]  debounced keys, active low (bit0 MODE, bit1 UP, bit2 DOWN)
//   key_press [2:0]  one-cycle pulse per key on its press edge
//   key_long  [2:0]  one-cycle pulse per key when the hold reaches the long-press time
//   mode      [1:0]  current mode
//   set_val   [15:0] user parameter value
// Modports: master drives keys and observes events (stimulus side),
//           slave samples keys and drives events (key_ctrl side).
interface key_ctrl_if;
  logic [2:0]  key_value;
  logic [2:0]  key_press;
  logic [2:0]  key_long;
  logic [1:0]  mode;
  logic [15:0] set_val;

  modport master (
    output key_value,
    input  key_press,
    input  key_long,
    input  mode,
    input  set_val
  );

  modport slave (
    input  key_value,
    output key_press,
    output key_long,
    output mode,
    output set_val
  );
endinterface

// File: rtl/key_ctrl.sv
// Three-key controller: press / long-press / auto-repeat detection driving a mode and a saturating value.
// Latency: all outputs registered; key_press and value steps appear one cycle after the sampling edge.
// Backpressure: none; keys are sampled every cycle and events are never stalled.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    key_ctrl_if.slave: key_value in; key_press, key_long, mode, set_val out
//
// LONG_CYCLES must be >= 2 and REPEAT_CYCLES >= 1; both must fit in the 26-bit hold counter.
module key_ctrl #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter logic [15:0] VAL_INIT      = 16'd1000,
  parameter logic [15:0] VAL_MIN       = 16'd0,
  parameter logic [15:0] VAL_MAX       = 16'd9999,
  parameter logic [15:0] VAL_STEP      = 16'd10,
  parameter int unsigned MODE_NUM      = 3
) (
  input logic       clk,
  input logic       rst_n,
  key_ctrl_if.slave bus
);

  // The press edge itself counts as the first held cycle, so the long press
  // fires when the counter (cleared on that edge) has reached LONG_CYCLES-2:
  // that is LONG_CYCLES consecutive low samples in total.
  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 2);
  localparam logic [25:0] REP_LAST  = 26'(REPEAT_CYCLES - 1);
  localparam logic [1:0]  MODE_LAST = 2'(MODE_NUM - 1);
  localparam logic [15:0] UP_LIM    = VAL_MAX - VAL_STEP;
  localparam logic [15:0] DN_LIM    = VAL_MIN + VAL_STEP;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t      state    [3];
  logic [25:0] hold_cnt [3];
  logic [2:0]  key_d;

  logic [2:0]  press_e;
  logic [2:0]  release_e;
  logic [2:0]  long_hit;
  logic [2:0]  rep_hit;
  logic        step_up;
  logic        step_dn;
  logic        short_mode;

  always_comb begin
    press_e   = key_d & ~bus.key_value;
    release_e = ~key_d & bus.key_value;
    long_hit  = '0;
    rep_hit   = '0;
    for (int i = 0; i < 3; i++) begin
      // A release always wins over a same-cycle threshold hit.
      if (state[i] == HOLD && !release_e[i] && hold_cnt[i] == LONG_LAST)
        long_hit[i] = 1'b1;
      if (state[i] == REPEAT && !release_e[i] && hold_cnt[i] == REP_LAST)
        rep_hit[i] = 1'b1;
    end
    step_up    = press_e[1] | rep_hit[1];
    step_dn    = press_e[2] | rep_hit[2];
    // MODE released before its long press fired counts as a short press.
    short_mode = (state[0] == HOLD) && release_e[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d         <= 3'b111;
      bus.key_press <= '0;
      bus.key_long  <= '0;
      bus.mode      <= '0;
      bus.set_val   <= VAL_INIT;
      for (int i = 0; i < 3; i++) begin
        state[i]    <= IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      key_d         <= bus.key_value;
      bus.key_press <= press_e;
      bus.key_long  <= long_hit;

      // Counters are cleared at every threshold, so they never wrap.
      for (int i = 0; i < 3; i++) begin
        case (state[i])
          IDLE: begin
            if (press_e[i]) begin
              state[i]    <= HOLD;
              hold_cnt[i] <= '0;
            end
          end
          HOLD: begin
            if (release_e[i]) begin
              state[i]    <= IDLE;
              hold_cnt[i] <= '0;
            end else if (long_hit[i]) begin
              state[i]    <= REPEAT;
              hold_cnt[i] <= '0;
            end else begin
              hold_cnt[i] <= hold_cnt[i] + 26'd1;
            end
          end
          REPEAT: begin
            if (release_e[i]) begin
              state[i]    <= IDLE;
              hold_cnt[i] <= '0;
            end else if (rep_hit[i]) begin
              hold_cnt[i] <= '0;
            end else begin
              hold_cnt[i] <= hold_cnt[i] + 26'd1;
            end
          end
          default: begin
            state[i]    <= IDLE;
            hold_cnt[i] <= '0;
          end
        endcase
      end

      if (short_mode)
        bus.mode <= (bus.mode == MODE_LAST) ? 2'd0 : bus.mode + 2'd1;

      // Long MODE restores the value and overrides any same-cycle step;
      // simultaneous UP and DOWN steps cancel.
      if (long_hit[0])
        bus.set_val <= VAL_INIT;
      else if (step_up && !step_dn)
        bus.set_val <= (bus.set_val > UP_LIM) ? VAL_MAX : bus.set_val + VAL_STEP;
      else if (step_dn && !step_up)
        bus.set_val <= (bus.set_val < DN_LIM) ? VAL_MIN : bus.set_val - VAL_STEP;
    end
  end

endmodule

// File: tb/tb_key_ctrl.sv
// Testbench for key_ctrl: table-driven key sequences plus hand-written corner cases,
// with every output event checked against a queue of expected events.
// Runs with LONG=20, REPEAT=5, INIT=100, MIN=0, MAX=200, STEP=10, MODE_NUM=3.
module tb_key_ctrl;

  localparam int LONG = 20;
  localparam int REP  = 5;
  localparam int INIT = 100;
  localparam int VMIN = 0;
  localparam int VMAX = 200;
  localparam int STEP = 10;
  localparam int MNUM = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  key_ctrl_if bus ();

  key_ctrl #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .VAL_INIT      (16'd100),
    .VAL_MIN       (16'd0),
    .VAL_MAX       (16'd200),
    .VAL_STEP      (16'd10),
    .MODE_NUM      (MNUM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 press, 1 long, 2 set_val change, 3 mode change
  typedef struct {
    int kind;
    int key;
    int at;
    int val;
  } ev_t;

  typedef struct {
    logic [2:0] keys;
    int         len;
    int         exp_sv;
    int         exp_md;
  } vec_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  sv_m;
  int  md_m;
  int  prev_sv;
  int  prev_md;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int key, input int at, input int val);
    ev_t e;
    e.kind = kind; e.key = key; e.at = at; e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int kind, input int key, input int val);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got kind %0d key %0d val %0d at cycle %0d, expected no event",
               kind, key, val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.key != key || e.val != val || e.at != cyc) begin
        n_bad++;
        $display("FAIL sb_event: got kind %0d key %0d val %0d cycle %0d, expected kind %0d key %0d val %0d cycle %0d",
                 kind, key, val, cyc, e.kind, e.key, e.val, e.at);
      end
    end
  endtask

  // Observes output events once per cycle, away from the active edge.
  task automatic monitor();
    if (rst_n) begin
      for (int k = 0; k < 3; k++) if (bus.key_press[k]) sb_check(0, k, 0);
      for (int k = 0; k < 3; k++) if (bus.key_long[k])  sb_check(1, k, 0);
      if (int'(bus.set_val) != prev_sv) sb_check(2, 0, int'(bus.set_val));
      if (int'(bus.mode) != prev_md)    sb_check(3, 0, int'(bus.mode));
    end
    prev_sv = int'(bus.set_val);
    prev_md = int'(bus.mode);
  endtask

  // Hold the keys in mask low for len sampling edges, optionally release,
  // and queue every output event the key behaviour implies.
  // Called #1 after a rising edge.
  task automatic hold(input logic [2:0] mask, input int len, input bit rel);
    int t0;
    bit up, dn, lng, rep;
    int nv;
    t0 = cyc + 1;
    bus.key_value = ~mask;
    for (int off = 0; off < len; off++) begin
      up  = 1'b0;
      dn  = 1'b0;
      lng = (off == LONG - 1);
      rep = (off > LONG - 1) && ((off - (LONG - 1)) % REP == 0);
      if (off == 0) begin
        for (int k = 0; k < 3; k++) if (mask[k]) push(0, k, t0, 0);
        up = mask[1];
        dn = mask[2];
      end
      if (lng) for (int k = 0; k < 3; k++) if (mask[k]) push(1, k, t0 + off, 0);
      if (rep) begin
        up = up | mask[1];
        dn = dn | mask[2];
      end
      nv = sv_m;
      if (lng && mask[0])  nv = INIT;
      else if (up && !dn)  nv = (sv_m > VMAX - STEP) ? VMAX : sv_m + STEP;
      else if (dn && !up)  nv = (sv_m < VMIN + STEP) ? VMIN : sv_m - STEP;
      if (nv != sv_m) push(2, 0, t0 + off, nv);
      sv_m = nv;
    end
    if (rel && mask[0] && len < LONG) begin
      md_m = (md_m == MNUM - 1) ? 0 : md_m + 1;
      push(3, 0, t0 + len, md_m);
    end
    repeat (len) @(posedge clk);
    #1;
    if (rel) begin
      bus.key_value = 3'b111;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_press"}, int'(bus.key_press), 0);
    chk({tag, "_long"},  int'(bus.key_long),  0);
    chk({tag, "_mode"},  int'(bus.mode),      0);
    chk({tag, "_sv"},    int'(bus.set_val),   INIT);
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{3'b010, 3,  110, 0};  // short UP
    tbl[1]  = '{3'b100, 3,  100, 0};  // short DOWN
    tbl[2]  = '{3'b010, 32, 130, 0};  // UP hold: press, long, two repeats
    tbl[3]  = '{3'b100, 2,  120, 0};
    tbl[4]  = '{3'b001, 3,  120, 1};  // short MODE presses wrap 1,2,0
    tbl[5]  = '{3'b001, 1,  120, 2};
    tbl[6]  = '{3'b001, 4,  120, 0};
    tbl[7]  = '{3'b010, 5,  130, 0};
    tbl[8]  = '{3'b010, 1,  140, 0};
    tbl[9]  = '{3'b010, 1,  150, 0};
    tbl[10] = '{3'b001, 25, 100, 0};  // long MODE restores value, mode kept
    tbl[11] = '{3'b110, 3,  100, 0};  // UP+DOWN together cancel
    tbl[12] = '{3'b100, 20, 90,  0};  // long DOWN itself does not step
    tbl[13] = '{3'b010, 3,  100, 0};

    rst_n         = 1'b0;
    bus.key_value = 3'b111;
    sv_m          = INIT;
    md_m          = 0;
    prev_sv       = INIT;
    prev_md       = 0;

    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      hold(tbl[i].keys, tbl[i].len, 1'b1);
      chk($sformatf("vec%0d_sv", i), int'(bus.set_val), tbl[i].exp_sv);
      chk($sformatf("vec%0d_mode", i), int'(bus.mode), tbl[i].exp_md);
    end

    // UP saturation
    for (int i = 0; i < 12; i++) hold(3'b010, 2, 1'b1);
    chk("sat_up", int'(bus.set_val), 200);

    // DOWN saturation
    for (int i = 0; i < 25; i++) hold(3'b100, 2, 1'b1);
    chk("sat_dn", int'(bus.set_val), 0);

    // Long MODE restores from 0; release from REPEAT keeps the mode
    hold(3'b001, 20, 1'b1);
    chk("restore_sv", int'(bus.set_val), 100);
    chk("restore_mode", int'(bus.mode), 0);
    hold(3'b001, 2, 1'b1);
    chk("mode_pre_reset", int'(bus.mode), 1);

    // Reset in the middle of an UP auto-repeat with set_val at 140
    hold(3'b010, 37, 1'b0);
    chk("sb_drained", sb.size(), 0);
    chk("rep_sv", int'(bus.set_val), 140);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    sv_m  = INIT;
    md_m  = 0;
    rst_n = 1'b1;
    // UP is still low: the first sampling edge is a fresh press
    hold(3'b010, 3, 1'b1);
    chk("post_rst_sv", int'(bus.set_val), 110);
    chk("post_rst_mode", int'(bus.mode), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_left", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LONG_CYCLES, 50_000_000: hold cycles from press to long-press event.
- REPEAT_CYCLES, 5_000_000: cycles between auto-repeat events after long press.
- VAL_INIT, 16'd1000: set_val reset and restore value.
- VAL_MIN, 16'd0: set_val lower bound.
- VAL_MAX, 16'd9999: set_val upper bound.
- VAL_STEP, 16'd10: set_val increment/decrement.
- MODE_NUM, 3: number of modes, 2..4.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- key_value, in, 3: debounced keys, active low, held low while pressed. Bit0 = MODE, bit1 = UP, bit2 = DOWN.
- key_press, out, 3: one-cycle pulse per key on press edge.
- key_long, out, 3: one-cycle pulse per key when hold reaches LONG_CYCLES.
- mode, out, 2: current mode, 0..MODE_NUM-1.
- set_val, out, 16: user parameter value.

REQ-003 One clock domain; all outputs registered.

Function
REQ-004 Previous-sample register key_d[2:0] holds key_value; a press edge for key i is key_d[i]=1 and key_value[i]=0; a release edge is key_d[i]=0 and key_value[i]=1.
REQ-005 key_press[i] is high for exactly one cycle, on the cycle after the clock edge that samples the press edge.
REQ-006 Each key has an independent 3-state FSM:
- IDLE: on press edge -> HOLD, hold_cnt=0.
- HOLD: hold_cnt increments each cycle; at hold_cnt==LONG_CYCLES-1 pulse key_long[i] -> REPEAT, hold_cnt=0; on release -> IDLE.
- REPEAT: hold_cnt increments; at hold_cnt==REPEAT_CYCLES-1 an internal rep[i] pulse fires and hold_cnt=0; on release -> IDLE.
REQ-007 Release in any state returns to IDLE in one cycle and clears hold_cnt; hold_cnt is 26 bits and never wraps.
REQ-008 UP step event = key_press[1] or rep[1]; DOWN step event = key_press[2] or rep[2]; set_val updates on the same edge that asserts the event pulse.
REQ-009 UP saturates: if set_val > VAL_MAX-VAL_STEP then set_val=VAL_MAX, else set_val+VAL_STEP. DOWN saturates symmetrically at VAL_MIN. There is no wrap-around.
REQ-010 UP and DOWN step events in the same cycle: set_val unchanged; both key_press pulses still issue.
REQ-011 key_long[1] and key_long[2] themselves do not step set_val; only rep pulses step it.
REQ-012 MODE key:
- Release from HOLD (short press): advance mode; MODE_NUM-1 wraps to 0.
- Release from REPEAT: mode unchanged.
- key_long[0]: set_val=VAL_INIT, overriding any same-cycle UP/DOWN step.
- rep[0] has no effect.
REQ-013 A mode change does not alter set_val.

Reset
REQ-014 Asynchronous reset values: key_d=3'b111, all FSMs IDLE, hold_cnt=0, key_press=0, key_long=0, mode=0, set_val=VAL_INIT.
REQ-015 Reset asserted mid-hold aborts the hold with no pulse. If a key is still low when reset is released, that is a new press edge on the first sampling edge.

Verification
(Parameters: LONG_CYCLES=20, REPEAT_CYCLES=5, VAL_INIT=100, VAL_MIN=0, VAL_MAX=200, VAL_STEP=10, MODE_NUM=3; press edge sampled at edge t0.)
REQ-016 Short press: key_value[1] low for 3 cycles -> one key_press[1] pulse at t0+1, set_val=110, no key_long.
REQ-017 Hold-repeat: key_value[1] low for 32 cycles -> key_press[1] at t0+1, key_long[1] at t0+20, rep steps at t0+25 and t0+30, final set_val=130.
REQ-018 Saturation and simultaneity:
- 12 UP presses -> set_val=200.
- 25 DOWN presses -> set_val=0.
- UP and DOWN pressed on the same cycle from 100 -> set_val stays 100 and both key_press bits pulse.
REQ-019 Mode:
- Three short MODE presses -> mode 1, 2, 0.
- MODE held 25 cycles with set_val=150 -> key_long[0] pulses once, set_val=100, mode unchanged after release.
REQ-020 Reset mid-REPEAT on UP with set_val=140 -> all outputs take reset values immediately. With UP still low after release, key_press[1] pulses one cycle after the first edge and set_val=110.
